// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer and HI/LO register owner.
// Ports: clk/rst, EX request + hilo_read/flush in, stall/hi/lo/busy/timeout out,
//        mul_op/mul_a/mul_b -> multiplier, mul_c/mul_done <- multiplier,
//        div_start/div_signed/div_a/div_b -> divider, div_q/div_r/div_done <- divider.
module ex_muldiv_ctrl #(
  parameter int WAIT_LIMIT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        hilo_read,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        timeout,
  output logic [1:0]  mul_op,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_c,
  input  logic        mul_done,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MISS  = 3'd1;
  localparam logic [2:0] S_MWAIT = 3'd2;
  localparam logic [2:0] S_DISS  = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [2:0]    r_state;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_signed;
  logic          r_discard;
  logic          r_timeout;
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_discard;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_limit;

  assign w_accept  = (r_state == S_IDLE) & req_valid & ~flush;
  // A flush seen in the completion cycle also drops the result.
  assign w_discard = r_discard | flush;
  assign w_cnt_nxt = r_cnt + 1'b1;
  // Fires on the last permitted WAIT cycle; a done in that cycle wins.
  assign w_limit   = (w_cnt_nxt == CW'(WAIT_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hi      <= '0;
      r_lo      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_signed  <= 1'b0;
      r_discard <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_discard <= 1'b0;
          if (w_accept) begin
            case (req_op)
              OP_MULT, OP_MULTU: begin
                r_a      <= req_a;
                r_b      <= req_b;
                r_signed <= (req_op == OP_MULT);
                r_state  <= S_MISS;
              end
              OP_DIV, OP_DIVU: begin
                r_a      <= req_a;
                r_b      <= req_b;
                r_signed <= (req_op == OP_DIV);
                r_state  <= S_DISS;
              end
              OP_MTHI: r_hi <= req_a;
              OP_MTLO: r_lo <= req_a;
              default: ;
            endcase
          end
        end
        S_MISS: begin
          r_discard <= w_discard;
          if (mul_done) begin
            r_cnt   <= '0;
            r_state <= S_MWAIT;
          end
        end
        S_DISS: begin
          r_discard <= w_discard;
          r_cnt     <= '0;
          r_state   <= S_DWAIT;
        end
        S_MWAIT, S_DWAIT: begin
          r_discard <= w_discard;
          if ((r_state == S_MWAIT) ? mul_done : div_done) begin
            if (!w_discard) begin
              if (r_state == S_MWAIT) begin
                r_hi <= mul_c[63:32];
                r_lo <= mul_c[31:0];
              end else begin
                r_hi <= div_r;
                r_lo <= div_q;
              end
            end
            r_discard <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_limit) begin
            r_timeout <= 1'b1;
            r_discard <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign stall      = busy & (req_valid | hilo_read);
  assign hi         = r_hi;
  assign lo         = r_lo;
  assign timeout    = r_timeout;
  assign mul_op     = (r_state != S_MISS) ? 2'b00 :
                      (r_signed ? 2'b10 : 2'b01);
  assign mul_a      = r_a;
  assign mul_b      = r_b;
  assign div_start  = (r_state == S_DISS);
  assign div_signed = r_signed;
  assign div_a      = r_a;
  assign div_b      = r_b;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: unit models, directed scenarios, random traffic.
// Checked cycle by cycle against a transaction-level reference model.
module tb_ex_muldiv_ctrl;

  localparam int WL = 12;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        hilo_read;
  logic        flush;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        timeout;
  logic [1:0]  mul_op;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_c;
  logic        mul_done;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_done;

  ex_muldiv_ctrl #(.WAIT_LIMIT(WL)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .hilo_read(hilo_read), .flush(flush),
    .stall(stall), .hi(hi), .lo(lo),
    .busy(busy), .timeout(timeout),
    .mul_op(mul_op), .mul_a(mul_a), .mul_b(mul_b),
    .mul_c(mul_c), .mul_done(mul_done),
    .div_start(div_start), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r), .div_done(div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic s,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    longint x;
    longint y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      return 64'(x * y);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Returns {remainder, quotient}; /0 gives q=all ones, r=dividend.
  function automatic logic [63:0] divref(input logic s,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Multiplier model: accepts while done=1, result after 4 low cycles.
  int   mcnt;
  logic mul_rnd;
  always @(posedge clk) begin
    if (rst) begin
      mcnt     <= 0;
      mul_done <= 1'b1;
      mul_c    <= '0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_done <= 1'b1;
    end else if (mul_op != 2'b00 && mul_done) begin
      mcnt     <= 4;
      mul_done <= 1'b0;
      mul_c    <= prod(mul_op[1], mul_a, mul_b);
    end else begin
      mul_done <= mul_rnd ? ($urandom % 3 != 0) : 1'b1;
    end
  end

  // Divider model: done pulse div_lat edges after start, or never.
  int   dcnt;
  int   div_lat;
  logic div_hang;
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (rst) begin
      dcnt  <= 0;
      div_q <= '0;
      div_r <= '0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) div_done <= 1'b1;
    end else if (div_start && !div_hang) begin
      dcnt <= div_lat;
      {div_r, div_q} <= divref(div_signed, div_a, div_b);
    end
  end

  // Reference model: one outstanding operation record.
  logic        m_busy, m_div, m_sgn, m_issue, m_disc, m_to;
  int          m_wait;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [63:0] m_res;
  logic        e_stl, acc;

  task automatic step(input logic r, input logic v,
                      input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic rd, input logic fl);
    logic [1:0] e_mop;
    @(negedge clk);
    rst = r; req_valid = v; req_op = op;
    req_a = a; req_b = b; hilo_read = rd; flush = fl;
    #1;
    e_stl = m_busy & (v | rd);
    e_mop = (m_busy && !m_div && m_issue) ? (m_sgn ? 2'b10 : 2'b01) : 2'b00;
    chk("busy", busy, m_busy);
    chk("stall", stall, e_stl);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("timeout", timeout, m_to);
    chk("mul_op", mul_op, e_mop);
    chk("div_start", div_start, m_busy & m_div & m_issue);
    if (e_mop != 2'b00) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
    end
    if (m_busy && m_div && m_issue) begin
      chk("div_a", div_a, m_a);
      chk("div_b", div_b, m_b);
      chk("div_signed", div_signed, m_sgn);
    end
    acc = !m_busy && v && !fl;
    m_to = 1'b0;
    if (r) begin
      m_busy = 0; m_issue = 0; m_disc = 0;
      m_hi = '0; m_lo = '0; m_wait = 0;
    end else if (!m_busy) begin
      if (acc) begin
        case (op)
          3'd1, 3'd2, 3'd3, 3'd4: begin
            m_busy  = 1'b1;
            m_issue = 1'b1;
            m_disc  = 1'b0;
            m_div   = (op >= 3'd3);
            m_sgn   = (op == 3'd1) || (op == 3'd3);
            m_a = a; m_b = b;
            m_res = m_div ? divref(m_sgn, a, b) : prod(m_sgn, a, b);
          end
          3'd5: m_hi = a;
          3'd6: m_lo = a;
          default: ;
        endcase
      end
    end else begin
      if (fl) m_disc = 1'b1;
      if (m_issue) begin
        if (m_div || mul_done) begin
          m_issue = 1'b0;
          m_wait  = 0;
        end
      end else if (m_div ? div_done : mul_done) begin
        if (!m_disc) begin
          m_hi = m_res[63:32];
          m_lo = m_res[31:0];
        end
        m_busy = 1'b0;
      end else begin
        m_wait++;
        if (m_wait == WL) begin
          m_to   = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  // EX holds a request until the controller accepts it.
  task automatic hold(input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4 * WL; i++) begin
      step(0, 1, op, a, b, 0, 0);
      if (acc) return;
    end
    chk("hold_bound", 1, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0;
    hilo_read = 0; flush = 0;
    div_lat = 1; div_hang = 0; mul_rnd = 0;
    m_busy = 0; m_div = 0; m_sgn = 0; m_issue = 0; m_disc = 0;
    m_to = 0; m_wait = 0; m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
    m_res = 0; e_stl = 0; acc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_op", mul_op, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_div_b", div_b, 0);
    chk("rst_timeout", timeout, 0);

    step(0, 1, 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    idle(8);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    step(0, 1, 3'd2, 32'hFFFF_FFFF, 32'd2, 0, 0);
    idle(2);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 3'd0, 0, 0, 1, 0);
      if (!e_stl) break;
    end
    chk("mfhi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    div_lat = 10;
    step(0, 1, 3'd3, 32'd7, 32'd2, 0, 0);
    hold(3'd5, 32'hABCD, 0);
    chk("div_hi", hi, 32'd1);
    idle(1);
    chk("div_lo", lo, 32'd3);
    chk("mthi_after", hi, 32'hABCD);

    step(0, 1, 3'd6, 32'h1234, 0, 0, 0);
    chk("mtlo_busy", busy, 0);
    idle(1);
    chk("mtlo", lo, 32'h1234);
    step(0, 1, 3'd1, 32'd5, 32'd6, 0, 0);
    hold(3'd5, 32'h77, 0);
    idle(1);
    chk("mthi_pend", hi, 32'h77);
    chk("mult56", lo, 32'd30);

    step(0, 1, 3'd1, 32'd9, 32'd9, 0, 0);
    idle(2);
    step(0, 0, 3'd0, 0, 0, 0, 1);
    idle(6);
    chk("flush_hi", hi, 32'h77);
    chk("flush_lo", lo, 32'd30);
    step(0, 1, 3'd1, 32'd2, 32'd2, 0, 1);
    idle(1);
    chk("flush_idle", busy, 0);

    div_hang = 1;
    step(0, 1, 3'd4, 32'd100, 32'd7, 0, 0);
    idle(WL + 4);
    chk("to_lo", lo, 32'd30);
    chk("to_busy", busy, 0);
    div_hang = 0;

    step(0, 1, 3'd1, 32'd3, 32'd4, 0, 0);
    idle(3);
    step(1, 0, 3'd0, 0, 0, 0, 0);
    idle(1);
    chk("rstmid_hi", hi, 0);
    chk("rstmid_busy", busy, 0);

    mul_rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      div_lat  = $urandom_range(1, WL + 1);
      div_hang = ($urandom % 12 == 0);
      ra = ($urandom % 4 == 0) ? $urandom % 8 : $urandom;
      rb = ($urandom % 4 == 0) ? $urandom % 3 : $urandom;
      step(($urandom % 300 == 0), ($urandom % 3 == 0),
           3'($urandom % 8), ra, rb,
           ($urandom % 4 == 0), ($urandom % 20 == 0));
    end
    mul_rnd = 0;
    div_hang = 0;
    idle(2 * WL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
